vga_vram_arbiter: RTL and testbench

- Shares one single-port video RAM between the VGA display fetch and N_WR game-logic writers.
- The display always wins. Writers get idle cycles in the active region, plus a budgeted burst window per frame that opens on the VGA driver's animate pulse.
- Sits between the 800x600 timing driver and pixel-address logic on one side and the synchronous-read VRAM on the other.

---
 rtl/vga_vram_arbiter.sv | 151 +++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: the display read always wins, and writers are served round-robin on idle cycles.
// A per-frame flush window with a write budget opens on i_animate. Optional VGA_ARB_OVERRUN_EN adds a sticky o_overrun flag.
module vga_vram_arbiter #(
    parameter int N_WR      = 4,
    parameter int AW        = 19,
    parameter int DW        = 8,
    parameter int WR_BUDGET = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_animate,
    input  logic             i_frame_start,
    input  logic             i_disp_req,
    input  logic [AW-1:0]    i_disp_addr,
    output logic             o_disp_valid,
    output logic [DW-1:0]    o_disp_data,
    input  logic [N_WR-1:0]  i_wr_req,
    input  logic [N_WR*AW-1:0] i_wr_addr,
    input  logic [N_WR*DW-1:0] i_wr_data,
    output logic [N_WR-1:0]  o_wr_gnt,
    output logic [AW-1:0]    o_mem_addr,
    output logic             o_mem_we,
    output logic [DW-1:0]    o_mem_wdata,
    input  logic [DW-1:0]    i_mem_rdata,
    output logic             o_flush,
    output logic             o_frame_done
`ifdef VGA_ARB_OVERRUN_EN
    ,
    output logic             o_overrun
`endif
);

    localparam int PW = (N_WR > 1) ? $clog2(N_WR) : 1;
    localparam int CW = $clog2(WR_BUDGET + 1);
    localparam logic [CW-1:0] BUDGET = CW'(WR_BUDGET);
    localparam logic [PW-1:0] LAST_WR = PW'(N_WR - 1);

    typedef enum logic {S_DISPLAY, S_FLUSH} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            disp_valid_q;
    logic            frame_done_q, frame_done_d;

    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand_idx;
    int              cand;
    logic            wr_fire;

    // Round-robin scan starting at the pointer, wrapping modulo N_WR.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N_WR; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= N_WR) cand = cand - N_WR;
            cand_idx = PW'(cand);
            if (!gnt_any && i_wr_req[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    assign wr_fire = gnt_any && !i_disp_req && !i_rst;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        o_wr_gnt    = '0;
        if (!i_rst) begin
            if (i_disp_req) begin
                o_mem_addr = i_disp_addr;
            end else if (gnt_any) begin
                o_wr_gnt[gnt_idx] = 1'b1;
                o_mem_we          = 1'b1;
                o_mem_addr        = i_wr_addr[gnt_idx*AW +: AW];
                o_mem_wdata       = i_wr_data[gnt_idx*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        if (wr_fire) rr_d = (gnt_idx == LAST_WR) ? '0 : gnt_idx + 1'b1;
        case (state_q)
            S_DISPLAY: begin
                // A coincident frame start means the window would already be over.
                if (i_animate && !i_frame_start) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                end
            end
            S_FLUSH: begin
                if (wr_fire && cnt_q != BUDGET) cnt_d = cnt_q + 1'b1;
                if ((wr_fire && cnt_d == BUDGET) || i_frame_start) begin
                    state_d      = S_DISPLAY;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_DISPLAY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
        if (i_rst) begin
            state_q      <= S_DISPLAY;
            rr_q         <= '0;
            cnt_q        <= '0;
            disp_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            disp_valid_q <= i_disp_req;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_disp_valid = disp_valid_q;
    assign o_disp_data  = i_mem_rdata;
    assign o_flush      = (state_q == S_FLUSH);
    assign o_frame_done = frame_done_q;

`ifdef VGA_ARB_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Display traffic during the window, or the window closing with writers still pending.
    assign overrun_d = overrun_q ||
                       ((state_q == S_FLUSH) && (i_disp_req || (i_frame_start && |i_wr_req)));

    always_ff @(posedge i_clk) begin
        if (i_rst) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign o_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter (N_WR=4, WR_BUDGET=4).
// Display reads are scoreboarded through a queue, and write grants are checked cycle by cycle against tables.
module tb_vga_vram_arbiter;

    localparam int N_WR = 4;
    localparam int AW   = 19;
    localparam int DW   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 animate, frame_start, disp_req;
    logic [AW-1:0]        disp_addr;
    logic                 disp_valid;
    logic [DW-1:0]        disp_data;
    logic [N_WR-1:0]      wr_req, wr_gnt;
    logic [N_WR*AW-1:0]   wr_addr;
    logic [N_WR*DW-1:0]   wr_data;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata = '0;
    logic                 flush, frame_done;
`ifdef VGA_ARB_OVERRUN_EN
    logic                 overrun;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    vga_vram_arbiter #(.N_WR(N_WR), .AW(AW), .DW(DW), .WR_BUDGET(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_animate    (animate),
        .i_frame_start(frame_start),
        .i_disp_req   (disp_req),
        .i_disp_addr  (disp_addr),
        .o_disp_valid (disp_valid),
        .o_disp_data  (disp_data),
        .i_wr_req     (wr_req),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wr_gnt     (wr_gnt),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_flush      (flush),
        .o_frame_done (frame_done)
`ifdef VGA_ARB_OVERRUN_EN
        ,
        .o_overrun    (overrun)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // VRAM model: synchronous read returns the low address byte.
    always @(posedge clk) if (!mem_we) mem_rdata <= mem_addr[DW-1:0];

    // Scoreboard: a served display request must produce data one cycle later.
    always @(posedge clk) if (disp_req && !rst) exp_q.push_back(disp_addr[DW-1:0]);

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            check("disp_valid", disp_valid, 1'b1);
            check("disp_data", disp_data, e);
        end else begin
            check("disp_valid_idle", disp_valid, 1'b0);
        end
    end

    function automatic int onehot_idx(input logic [N_WR-1:0] v);
        int r = 0;
        for (int k = 0; k < N_WR; k++) if (v[k]) r = k;
        return r;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs and state flags, then advance.
    task automatic cyc(input logic r, input logic dreq, input logic [AW-1:0] daddr,
                       input logic anim, input logic fs, input logic [N_WR-1:0] req,
                       input logic [N_WR-1:0] egnt, input logic eflush, input logic efd);
        int k;
        rst = r; disp_req = dreq; disp_addr = daddr;
        animate = anim; frame_start = fs; wr_req = req;
        #1;
        check("wr_gnt", wr_gnt, egnt);
        check("mem_we", mem_we, |egnt);
        if (r) begin
            check("rst_addr", mem_addr, '0);
            check("rst_wdata", mem_wdata, '0);
        end else begin
            if (dreq) begin
                check("rd_addr", mem_addr, daddr);
            end else if (egnt != '0) begin
                k = onehot_idx(egnt);
                check("wr_addr", mem_addr, 32'h40000 + k * 32'h111);
                check("wr_data", mem_wdata, 32'hA0 + k);
            end
            check("flush", flush, eflush);
            check("frame_done", frame_done, efd);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; animate = 1'b0; frame_start = 1'b0; disp_req = 1'b0;
        disp_addr = '0; wr_req = '0;
        for (int k = 0; k < N_WR; k++) begin
            wr_addr[k*AW +: AW] = AW'(32'h40000 + k * 32'h111);
            wr_data[k*DW +: DW] = DW'(32'hA0 + k);
        end
        @(posedge clk); #1;

        // Reset: outputs forced quiet even with all writers requesting.
        cyc(1, 0, '0, 0, 0, 4'b1111, 4'b0000, 0, 0);
        cyc(1, 0, '0, 0, 0, 4'b1111, 4'b0000, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 0);
`ifdef VGA_ARB_OVERRUN_EN
        check("overrun_rst", overrun, 1'b0);
`endif

        // 1: three display reads.
        for (int i = 0; i < 3; i++) cyc(0, 1, 19'h00123, 0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // 2: all writers, full round-robin sweep plus wrap.
        cyc(0, 0, '0, 0, 0, 4'b1111, 4'b0001, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b1111, 4'b0010, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b1111, 4'b0100, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b1111, 4'b1000, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b1111, 4'b0001, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // 3: writers 1 and 3 interleaved with display reads; pointer is at 1.
        cyc(0, 1, 19'h75A50, 0, 0, 4'b1010, 4'b0000, 0, 0);
        cyc(0, 0, '0,        0, 0, 4'b1010, 4'b0010, 0, 0);
        cyc(0, 1, 19'h75A51, 0, 0, 4'b1010, 4'b0000, 0, 0);
        cyc(0, 0, '0,        0, 0, 4'b1010, 4'b1000, 0, 0);
        cyc(0, 1, 19'h75A52, 0, 0, 4'b1010, 4'b0000, 0, 0);
        cyc(0, 0, '0,        0, 0, 4'b1010, 4'b0010, 0, 0);
        cyc(0, 1, 19'h75A53, 0, 0, 4'b1010, 4'b0000, 0, 0);
        cyc(0, 0, '0,        0, 0, 4'b1010, 4'b1000, 0, 0);

        // 4: budget window of 4 grants to writer 2.
        cyc(0, 0, '0, 1, 0, 4'b0000, 4'b0000, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0, 0, 4'b0100, 4'b0100, 1, 0);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 1);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // 5: frame start cuts the window short; pointer is at 3.
        cyc(0, 0, '0, 1, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b0001, 4'b0001, 1, 0);
        cyc(0, 0, '0, 0, 0, 4'b0001, 4'b0001, 1, 0);
        cyc(0, 1, 19'h00ABC, 0, 0, 4'b0001, 4'b0000, 1, 0);
        cyc(0, 0, '0, 0, 1, 4'b0001, 4'b0001, 1, 0);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 1);
        cyc(0, 0, '0, 1, 1, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 0);
`ifdef VGA_ARB_OVERRUN_EN
        check("overrun_set", overrun, 1'b1);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 0);
        check("overrun_sticky", overrun, 1'b1);
`endif

        // 6: reset in the middle of a window; pointer is at 1.
        cyc(0, 0, '0, 1, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b0010, 4'b0010, 1, 0);
        cyc(1, 0, '0, 0, 0, 4'b0010, 4'b0000, 0, 0);
        cyc(1, 0, '0, 0, 0, 4'b0010, 4'b0000, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b1111, 4'b0001, 0, 0);
        cyc(0, 0, '0, 0, 0, 4'b0000, 4'b0000, 0, 0);
`ifdef VGA_ARB_OVERRUN_EN
        check("overrun_cleared", overrun, 1'b0);
`endif

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
